// File: rtl/reaction_timer_pkg.sv
// rtl/reaction_timer_pkg.sv - shared state encoding and LFSR constants for the reaction timer
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ARMED,
        S_DONE,
        S_EARLY,
        S_TIMEOUT
    } state_t;

    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, loads seed on reset
module lfsr16
    import reaction_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= seed;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - reaction-test trial sequencer; BEST_TIME_EN adds best-time tracking
module reaction_timer_ctrl
    import reaction_timer_pkg::*;
#(
    parameter int          MIN_DELAY_MS    = 1000,
    parameter int          DELAY_SPAN_BITS = 12,
    parameter int          TIMEOUT_MS      = 9999,
    parameter int          CNT_W           = 14,
    parameter logic [15:0] LFSR_SEED       = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1k,
    input  logic             start_pulse,
    input  logic             react_pulse,
    output logic             led_on,
    output logic             busy,
    output logic [CNT_W-1:0] delay_ms,
    output logic [CNT_W-1:0] result_ms,
    output logic             result_valid,
    output logic             early,
    output logic             timeout,
    output logic [CNT_W-1:0] best_ms
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_MS - 1);
    localparam logic [CNT_W-1:0] TMO_VALUE = CNT_W'(TIMEOUT_MS);

    logic [15:0]      w_lfsr;
    logic             w_unused_lfsr;
    logic [CNT_W-1:0] w_new_delay;

    state_t           r_state;
    logic [CNT_W-1:0] r_dly_cnt;
    logic [CNT_W-1:0] r_ms_cnt;
    logic [CNT_W-1:0] r_delay_ms;
    logic [CNT_W-1:0] r_result_ms;
    logic             r_led_on;
    logic             r_busy;
    logic             r_result_valid;
    logic             r_early;
    logic             r_timeout;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (w_lfsr)
    );

    // Only the low DELAY_SPAN_BITS of the LFSR feed the delay
    assign w_unused_lfsr = ^w_lfsr;
    assign w_new_delay   = CNT_W'(MIN_DELAY_MS) + CNT_W'(w_lfsr[DELAY_SPAN_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_dly_cnt      <= '0;
            r_ms_cnt       <= '0;
            r_delay_ms     <= '0;
            r_result_ms    <= '0;
            r_led_on       <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_early        <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (react_pulse) begin
                        r_state        <= S_EARLY;
                        r_result_ms    <= '0;
                        r_result_valid <= 1'b1;
                        r_early        <= 1'b1;
                        r_busy         <= 1'b0;
                    end else if (tick_1k) begin
                        r_dly_cnt <= r_dly_cnt - ONE;
                        if (r_dly_cnt == ONE) begin
                            r_state  <= S_ARMED;
                            r_ms_cnt <= '0;
                            r_led_on <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    // react wins over a same-cycle tick, so the pre-tick count is reported
                    if (react_pulse) begin
                        r_state        <= S_DONE;
                        r_result_ms    <= r_ms_cnt;
                        r_result_valid <= 1'b1;
                        r_led_on       <= 1'b0;
                        r_busy         <= 1'b0;
                    end else if (tick_1k) begin
                        if (r_ms_cnt == TMO_LAST) begin
                            r_state        <= S_TIMEOUT;
                            r_result_ms    <= TMO_VALUE;
                            r_result_valid <= 1'b1;
                            r_led_on       <= 1'b0;
                            r_busy         <= 1'b0;
                            r_timeout      <= 1'b1;
                        end else begin
                            r_ms_cnt <= r_ms_cnt + ONE;
                        end
                    end
                end
                default: begin
                    if (start_pulse) begin
                        r_state    <= S_WAIT;
                        r_dly_cnt  <= w_new_delay;
                        r_delay_ms <= w_new_delay;
                        r_busy     <= 1'b1;
                        r_early    <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef BEST_TIME_EN
    logic [CNT_W-1:0] r_best_ms;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_best_ms <= '1;
        end else if (r_state == S_ARMED && react_pulse && r_ms_cnt < r_best_ms) begin
            r_best_ms <= r_ms_cnt;
        end
    end

    assign best_ms = r_best_ms;
`else
    assign best_ms = '0;
`endif

    assign led_on       = r_led_on;
    assign busy         = r_busy;
    assign delay_ms     = r_delay_ms;
    assign result_ms    = r_result_ms;
    assign result_valid = r_result_valid;
    assign early        = r_early;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - directed and randomized trials against a behavioural trial model
module tb_reaction_timer_ctrl;

    localparam int          MIN_DLY = 3;
    localparam int          SPAN    = 2;
    localparam int          TMO     = 20;
    localparam int          W       = 8;
    localparam logic [15:0] SEED    = 16'hACE1;
`ifdef BEST_TIME_EN
    localparam int BEST_RST = 255;
`else
    localparam int BEST_RST = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tick_1k = 1'b0;
    logic         start_pulse = 1'b0;
    logic         react_pulse = 1'b0;
    logic         led_on;
    logic         busy;
    logic [W-1:0] delay_ms;
    logic [W-1:0] result_ms;
    logic         result_valid;
    logic         early;
    logic         timeout;
    logic [W-1:0] best_ms;

    reaction_timer_ctrl #(
        .MIN_DELAY_MS    (MIN_DLY),
        .DELAY_SPAN_BITS (SPAN),
        .TIMEOUT_MS      (TMO),
        .CNT_W           (W),
        .LFSR_SEED       (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1k      (tick_1k),
        .start_pulse  (start_pulse),
        .react_pulse  (react_pulse),
        .led_on       (led_on),
        .busy         (busy),
        .delay_ms     (delay_ms),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .early        (early),
        .timeout      (timeout),
        .best_ms      (best_ms)
    );

    always #5 clk = ~clk;

    // Reference pseudo-random sequence: shift left, feedback from taps 16,14,13,11
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int rv_count = 0;
    int led_cycles = 0;
    always @(negedge clk) begin
        if (result_valid === 1'b1) rv_count++;
        if (led_on === 1'b1) led_cycles++;
    end

    int total = 0;
    int bad = 0;
    int exp_delay = 0;
    int m_best = BEST_RST;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic s, input logic r);
        tick_1k = t;
        start_pulse = s;
        react_pulse = r;
        @(negedge clk);
        tick_1k = 1'b0;
        start_pulse = 1'b0;
        react_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            cyc(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_led"}, led_on, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_delay"}, delay_ms, 0);
        chk({tag, "_result"}, result_ms, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_early"}, early, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_best"}, best_ms, BEST_RST);
    endtask

    task automatic start_trial();
        exp_delay = MIN_DLY + int'(m_lfsr[SPAN-1:0]);
        cyc(1'b0, 1'b1, 1'b0);
        chk("start_busy", busy, 1);
        chk("start_delay", delay_ms, exp_delay);
        chk("start_led", led_on, 0);
        chk("start_flags", {early, timeout}, 0);
    endtask

    task automatic react_expect(input string tag, input int expv, input logic t);
        int rv0;
        rv0 = rv_count;
        cyc(t, 1'b0, 1'b1);
        chk({tag, "_result"}, result_ms, expv);
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_led"}, led_on, 0);
        chk({tag, "_busy"}, busy, 0);
        idle(2);
        chk({tag, "_valid_once"}, rv_count - rv0, 1);
    endtask

    task automatic done_trial(input string tag, input int r);
        start_trial();
        ticks(exp_delay - 1);
        chk({tag, "_led_pre"}, led_on, 0);
        ticks(1);
        chk({tag, "_led_on"}, led_on, 1);
        ticks(r);
        react_expect(tag, r, 1'b0);
`ifdef BEST_TIME_EN
        if (r < m_best) m_best = r;
`endif
        chk({tag, "_best"}, best_ms, m_best);
    endtask

    task automatic early_trial(input string tag);
        int led0;
        start_trial();
        led0 = led_cycles;
        ticks($urandom_range(0, exp_delay - 1));
        react_expect(tag, 0, 1'b0);
        chk({tag, "_early"}, early, 1);
        ticks(exp_delay + 2);
        chk({tag, "_led_never"}, led_cycles - led0, 0);
        chk({tag, "_best"}, best_ms, m_best);
    endtask

    task automatic timeout_trial(input string tag);
        start_trial();
        ticks(exp_delay);
        chk({tag, "_led_on"}, led_on, 1);
        ticks(TMO - 1);
        chk({tag, "_not_yet"}, {timeout, led_on}, 2'b01);
        ticks(1);
        chk({tag, "_timeout"}, timeout, 1);
        chk({tag, "_result"}, result_ms, TMO);
        chk({tag, "_led_off"}, {led_on, busy}, 0);
        chk({tag, "_best"}, best_ms, m_best);
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        chk_reset_state("reset");

        done_trial("t1", 5);
        early_trial("t2");
        timeout_trial("t3");

        start_trial();
        ticks(exp_delay + 7);
        react_expect("t4", 7, 1'b1);
`ifdef BEST_TIME_EN
        if (7 < m_best) m_best = 7;
`endif

        start_trial();
        ticks(exp_delay + 3);
        begin
            int d0;
            d0 = exp_delay;
            cyc(1'b0, 1'b1, 1'b0);
            chk("t5_led", led_on, 1);
            chk("t5_busy", busy, 1);
            chk("t5_delay", delay_ms, d0);
        end
        ticks(2);
        react_expect("t5", 5, 1'b0);

        start_trial();
        ticks(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_best = BEST_RST;
        chk_reset_state("t6");

        done_trial("t7a", 9);
        done_trial("t7b", 4);
        done_trial("t7c", 6);
`ifdef BEST_TIME_EN
        chk("t7_best_final", best_ms, 4);
`endif

        for (int k = 0; k < 10; k++) begin
            int kind;
            kind = $urandom_range(0, 5);
            if (kind == 0)      early_trial("rnd_early");
            else if (kind == 1) timeout_trial("rnd_tmo");
            else                done_trial("rnd_done", $urandom_range(0, TMO - 1));
            cyc(1'b0, 1'b0, 1'b1);
            chk("rnd_idle_react", result_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
